modn_updown_counter: RTL and testbench
======================================

Name: modn_updown_counter

Overview:
- Parametrised modulo-N counter with up/down mode, synchronous load, enable and built-in prescaler.
- Successor to the team's fixed mod-13 display counter.
- The prescaler produces a one-cycle step-enable tick; no derived clock is generated, so the whole block runs on the single board clock.
- Drives one 7-segment digit through the team's bin_to_7seg block and emits a terminal-count pulse for cascading digits.

Parameters:
- MODULUS, 13: counter modulus N; legal 2..2**CNT_W.
- CNT_W, 4: width of count and load_val.
- PRESCALE_DIV, 50000000: board-clock cycles per count step; legal >= 1; 1 means step on every enabled cycle.
- PRE_W, 26: prescaler register width; must satisfy 2**PRE_W >= PRESCALE_DIV.

Ports:
- clk, input, 1: board clock; all state on rising edge.
- reset, input, 1: synchronous, active-high reset; sampled on rising clk.
- en, input, 1: count enable; gates both the prescaler and the stepping.
- up, input, 1: direction; 1 = increment, 0 = decrement.
- load, input, 1: synchronous load strobe.
- load_val, input, CNT_W: value captured on load.
- count, output, CNT_W: registered counter value.
- tick, output, 1: registered one-cycle step pulse from the prescaler.
- tc, output, 1: registered one-cycle terminal-count (wrap) pulse.
- seg, output, 7: 7-segment pattern of count[3:0], produced by a bin_to_7seg instance.

Behaviour:
- Reset values: count=0, prescaler=0, tick=0, tc=0. seg shows the digit 0 (combinational from count).
- Priority per edge: reset > load > step > hold.
- Prescaler (pre):
  - en=1: pre increments; when pre==PRESCALE_DIV-1, pre wraps to 0 and tick<=1 for exactly one cycle.
  - en=0: pre holds and tick<=0.
  - PRESCALE_DIV=1: tick=1 on every cycle following an en=1 cycle.
- Step condition: tick==1 && en==1, evaluated in the cycle tick is high. count changes on the following edge, so there is one cycle of latency from tick to count.
- Up step: count==MODULUS-1 -> 0 with tc<=1; otherwise count+1.
- Down step: count==0 -> MODULUS-1 with tc<=1; otherwise count-1.
- tc is 0 in every cycle that does not follow a wrap. tc rises in the same cycle that count shows the wrapped value.
- Load:
  - count<=load_val.
  - load_val >= MODULUS saturates to MODULUS-1.
  - pre<=0, tick<=0, tc<=0.
  - A pending tick in the same cycle is discarded, so a full PRESCALE_DIV interval follows every load.
- The up signal is sampled only in step cycles. Changing direction mid-sequence takes effect on the next step, with no extra delay.
- en deasserted in a tick cycle: the step is suppressed and count holds.
- Reset mid-operation, including during load or tick, wins unconditionally and gives the reset values on the next edge.
- count never takes a value >= MODULUS.
- All arithmetic is done in CNT_W bits. With MODULUS=2**CNT_W, wrap is natural overflow, but tc must still pulse.
- seg: for CNT_W<4, count is zero-extended to 4 bits; for CNT_W>4, only the low nibble is shown.

Test Plan:
- MODULUS=13, PRESCALE_DIV=4, up=1, en=1 after reset:
  - count steps 0,1,...,12,0; each value is held for 4 cycles.
  - tc is high for exactly 1 cycle, when count becomes 0.
  - seg matches the bin_to_7seg pattern for each digit.
- Same config, up=0 from reset:
  - count goes 0 -> 12 at the first step, with tc=1 that cycle, then 11, 10, ...
- load=1 with load_val=9 coinciding with a tick cycle:
  - count=9 next cycle, with no step and tc=0.
  - The next step occurs exactly 4 cycles later.
- load_val=15 with MODULUS=13:
  - count=12; after the next up step, count=0 with tc=1.
- en=0 for 10 cycles mid-count at count=5:
  - count, pre and tick are frozen.
  - On en=1, stepping resumes from the held pre phase.
- reset=1 asserted together with load=1 at count=7:
  - count=0, tick=0, tc=0 next cycle.
  - After release, the first step occurs PRESCALE_DIV cycles later.
- MODULUS=16, CNT_W=4, PRESCALE_DIV=1:
  - count 15 -> 0 with tc=1; one step per cycle.

Source files
------------

// File: rtl/modn_updown_counter.sv
// modn_updown_counter: modulo-N up/down counter with synchronous load, enable
// and a built-in prescaler. The prescaler issues a one-cycle step tick rather
// than a derived clock, so everything runs on the single board clock. The low
// nibble of the count drives one 7-segment digit, and tc pulses on every wrap
// so that several digits can be cascaded.

`default_nettype none

// bin_to_7seg: hex digit to active-high segment pattern, bit order {g,f,e,d,c,b,a}.
module bin_to_7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Pure lookup, covering all sixteen hex digits.
  always_comb begin
    seg = 7'h00;
    case (digit)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

module modn_updown_counter #(
  parameter int MODULUS      = 13,
  parameter int CNT_W        = 4,
  parameter int PRESCALE_DIV = 50000000,
  parameter int PRE_W        = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic [6:0]       seg
);

  // Highest legal count. With MODULUS == 2**CNT_W this is all ones, so the
  // up-wrap is plain overflow, but the explicit compare still raises tc.
  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MODULUS - 1);
  // Last prescaler phase before the tick. With PRESCALE_DIV == 1 this is 0,
  // so pre stays at 0 and a tick follows every enabled cycle.
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

  logic [PRE_W-1:0] pre_reg;
  logic [PRE_W-1:0] pre_next;
  logic             tick_reg;
  logic             tick_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             tc_reg;
  logic             tc_next;

  logic             step;
  logic [CNT_W-1:0] load_sat;
  logic [3:0]       nibble;

  // A step happens only while the registered tick is high and the counter is
  // still enabled. Dropping en during the tick cycle swallows that step.
  assign step = tick_reg & en;

  // Out-of-range load values clamp to the top of the range, so count can
  // never reach MODULUS or above.
  assign load_sat = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  // Prescaler next state: a load restarts the interval and discards any
  // pending tick. en=0 freezes the phase, so stepping resumes where it stopped.
  always_comb begin
    pre_next  = pre_reg;
    tick_next = 1'b0;
    if (load) begin
      pre_next  = '0;
      tick_next = 1'b0;
    end else if (en) begin
      if (pre_reg == PRE_LAST) begin
        pre_next  = '0;
        tick_next = 1'b1;
      end else begin
        pre_next  = pre_reg + PRE_W'(1);
      end
    end
  end

  // Counter next state: load beats step, and step beats hold. Direction is
  // sampled only in step cycles. tc marks the edge where count takes the
  // wrapped value.
  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    if (load) begin
      count_next = load_sat;
    end else if (step) begin
      if (up) begin
        if (count_reg == MAX_VAL) begin
          count_next = '0;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end else begin
        if (count_reg == '0) begin
          count_next = MAX_VAL;
          tc_next    = 1'b1;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
    end
  end

  // State registers. Reset overrides load, tick and everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_reg   <= '0;
      tick_reg  <= 1'b0;
      count_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      pre_reg   <= pre_next;
      tick_reg  <= tick_next;
      count_reg <= count_next;
      tc_reg    <= tc_next;
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;
  assign tc    = tc_reg;

  // Display digit: narrow counters are zero-extended to a nibble, and wide
  // counters show only their low nibble.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nibble
      if (gi < CNT_W) begin : g_bit
        assign nibble[gi] = count_reg[gi];
      end else begin : g_zero
        assign nibble[gi] = 1'b0;
      end
    end
  endgenerate

  bin_to_7seg u_seg (
    .digit (nibble),
    .seg   (seg)
  );

endmodule

`default_nettype wire

// File: tb/tb_modn_updown_counter.sv
// Directed testbench for modn_updown_counter.
// Instance dut_a uses MODULUS=13 and PRESCALE_DIV=4, for the main counting,
// load, enable and reset cases. Instance dut_b uses MODULUS=16 and
// PRESCALE_DIV=1, for natural-overflow wraps with a step on every cycle.

`timescale 1ns/1ps

module tb_modn_updown_counter;

  logic       clk;

  logic       reset_a, en_a, up_a, load_a;
  logic [3:0] load_val_a;
  logic [3:0] count_a;
  logic       tick_a, tc_a;
  logic [6:0] seg_a;

  logic       reset_b, en_b, up_b, load_b;
  logic [3:0] load_val_b;
  logic [3:0] count_b;
  logic       tick_b, tc_b;
  logic [6:0] seg_b;

  int errors = 0;
  int checks = 0;

  modn_updown_counter #(
    .MODULUS(13), .CNT_W(4), .PRESCALE_DIV(4), .PRE_W(3)
  ) dut_a (
    .clk(clk), .reset(reset_a), .en(en_a), .up(up_a), .load(load_a),
    .load_val(load_val_a), .count(count_a), .tick(tick_a), .tc(tc_a), .seg(seg_a)
  );

  modn_updown_counter #(
    .MODULUS(16), .CNT_W(4), .PRESCALE_DIV(1), .PRE_W(1)
  ) dut_b (
    .clk(clk), .reset(reset_b), .en(en_b), .up(up_b), .load(load_b),
    .load_val(load_val_b), .count(count_b), .tick(tick_b), .tc(tc_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  // Reference 7-segment patterns, bit order {g,f,e,d,c,b,a}, active high.
  function automatic int seg_of(input int d);
    case (d)
      0: return 32'h3F;  1: return 32'h06;  2: return 32'h5B;  3: return 32'h4F;
      4: return 32'h66;  5: return 32'h6D;  6: return 32'h7D;  7: return 32'h07;
      8: return 32'h7F;  9: return 32'h6F; 10: return 32'h77; 11: return 32'h7C;
     12: return 32'h39; 13: return 32'h5E; 14: return 32'h79; 15: return 32'h71;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock edge, then sample 1 ns later, away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] c;
    logic       t;
    logic       tcx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic en, input logic up, input logic ld,
                     input logic [3:0] lv, input logic [3:0] c, input logic t, input logic tcx);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.ld = ld;
    v.lv = lv; v.c = c; v.t = t; v.tcx = tcx;
    vecs.push_back(v);
  endtask

  initial begin
    // Corner-case table for dut_a. Each row holds the inputs for one cycle and
    // the expected outputs after that cycle's edge.
    //   rst en up ld lv     count tick tc
    add(1, 0, 1, 0, 4'd0,  4'd0,  0, 0);  // r0  reset
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 0);  // r1  pre=1
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 0);  // r2  pre=2
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 0);  // r3  pre=3
    add(0, 1, 1, 0, 4'd0,  4'd0,  1, 0);  // r4  tick
    add(0, 1, 1, 1, 4'd9,  4'd9,  0, 0);  // r5  load 9 during the tick cycle, step discarded
    add(0, 1, 1, 0, 4'd0,  4'd9,  0, 0);  // r6
    add(0, 1, 1, 0, 4'd0,  4'd9,  0, 0);  // r7
    add(0, 1, 1, 0, 4'd0,  4'd9,  0, 0);  // r8
    add(0, 1, 1, 0, 4'd0,  4'd9,  1, 0);  // r9  tick four cycles after the load
    add(0, 1, 1, 0, 4'd0,  4'd10, 0, 0);  // r10 step
    add(0, 1, 1, 1, 4'd15, 4'd12, 0, 0);  // r11 load 15 saturates to 12
    add(0, 1, 1, 0, 4'd0,  4'd12, 0, 0);  // r12
    add(0, 1, 1, 0, 4'd0,  4'd12, 0, 0);  // r13
    add(0, 1, 1, 0, 4'd0,  4'd12, 0, 0);  // r14
    add(0, 1, 1, 0, 4'd0,  4'd12, 1, 0);  // r15 tick
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 1);  // r16 up-wrap, tc
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 0);  // r17 tc back low
    add(0, 1, 1, 1, 4'd5,  4'd5,  0, 0);  // r18 load 5, pre=0
    add(0, 1, 1, 0, 4'd0,  4'd5,  0, 0);  // r19 pre=1
    add(0, 1, 1, 0, 4'd0,  4'd5,  0, 0);  // r20 pre=2
    for (int i = 0; i < 10; i++)
      add(0, 0, 1, 0, 4'd0, 4'd5, 0, 0);  // r21..r30 en=0, everything frozen
    add(0, 1, 1, 0, 4'd0,  4'd5,  0, 0);  // r31 pre=3 (resumes from the held phase)
    add(0, 1, 1, 0, 4'd0,  4'd5,  1, 0);  // r32 tick
    add(0, 1, 1, 0, 4'd0,  4'd6,  0, 0);  // r33 step
    add(0, 1, 1, 0, 4'd0,  4'd6,  0, 0);  // r34
    add(0, 1, 1, 0, 4'd0,  4'd6,  0, 0);  // r35
    add(0, 1, 1, 0, 4'd0,  4'd6,  1, 0);  // r36 tick
    add(0, 0, 1, 0, 4'd0,  4'd6,  0, 0);  // r37 en=0 in the tick cycle: no step
    add(0, 1, 1, 0, 4'd0,  4'd6,  0, 0);  // r38 pre=1
    add(0, 1, 1, 0, 4'd0,  4'd6,  0, 0);  // r39
    add(0, 1, 1, 0, 4'd0,  4'd6,  0, 0);  // r40
    add(0, 1, 1, 0, 4'd0,  4'd6,  1, 0);  // r41 tick
    add(0, 1, 1, 0, 4'd0,  4'd7,  0, 0);  // r42 step to 7
    add(0, 1, 1, 0, 4'd0,  4'd7,  0, 0);  // r43
    add(1, 1, 1, 1, 4'd3,  4'd0,  0, 0);  // r44 reset together with load at count 7
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 0);  // r45
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 0);  // r46
    add(0, 1, 1, 0, 4'd0,  4'd0,  0, 0);  // r47
    add(0, 1, 1, 0, 4'd0,  4'd0,  1, 0);  // r48 tick PRESCALE_DIV cycles after release
    add(0, 1, 1, 0, 4'd0,  4'd1,  0, 0);  // r49 step up
    add(0, 1, 0, 0, 4'd0,  4'd1,  0, 0);  // r50 direction now down
    add(0, 1, 0, 0, 4'd0,  4'd1,  0, 0);  // r51
    add(0, 1, 0, 0, 4'd0,  4'd1,  1, 0);  // r52 tick
    add(0, 1, 0, 0, 4'd0,  4'd0,  0, 0);  // r53 step down to 0
    add(0, 1, 0, 0, 4'd0,  4'd0,  0, 0);  // r54
    add(0, 1, 0, 0, 4'd0,  4'd0,  0, 0);  // r55
    add(0, 1, 0, 0, 4'd0,  4'd0,  1, 0);  // r56 tick
    add(0, 1, 0, 0, 4'd0,  4'd12, 0, 1);  // r57 down-wrap, tc
    add(0, 1, 0, 0, 4'd0,  4'd12, 0, 0);  // r58
    add(0, 1, 0, 0, 4'd0,  4'd12, 0, 0);  // r59
    add(0, 1, 0, 0, 4'd0,  4'd12, 1, 0);  // r60 tick
    add(1, 1, 0, 0, 4'd0,  4'd0,  0, 0);  // r61 reset in a step cycle wins
    add(0, 0, 0, 0, 4'd0,  4'd0,  0, 0);  // r62

    clk = 1'b0;
    reset_a = 1'b1; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; load_val_a = 4'd0;
    reset_b = 1'b1; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; load_val_b = 4'd0;

    // Reset state.
    cyc(); cyc();
    chk("reset count", 32'(count_a), 0);
    chk("reset tick", 32'(tick_a), 0);
    chk("reset tc", 32'(tc_a), 0);
    chk("reset seg", 32'(seg_a), 32'h3F);

    // Up count: each value is held for 4 cycles, and tc fires once on 12 -> 0.
    reset_a = 1'b0; en_a = 1'b1; up_a = 1'b1;
    for (int k = 1; k <= 56; k++) begin
      int s;
      cyc();
      s = (k - 1) / 4;
      $display("up k=%0d: count=%0d tick=%0b tc=%0b seg=%02h", k, count_a, tick_a, tc_a, seg_a);
      chk($sformatf("up count k=%0d", k), 32'(count_a), s % 13);
      chk($sformatf("up tick k=%0d", k), 32'(tick_a), (k % 4 == 0) ? 1 : 0);
      chk($sformatf("up tc k=%0d", k), 32'(tc_a), (k > 1 && (k - 1) % 52 == 0) ? 1 : 0);
      chk($sformatf("up seg k=%0d", k), 32'(seg_a), seg_of(s % 13));
    end

    // Down count from reset: 0 -> 12 with tc at the first step, then 11, 10.
    reset_a = 1'b1;
    cyc();
    reset_a = 1'b0; en_a = 1'b1; up_a = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      int s;
      cyc();
      s = (k - 1) / 4;
      $display("down k=%0d: count=%0d tick=%0b tc=%0b", k, count_a, tick_a, tc_a);
      chk($sformatf("down count k=%0d", k), 32'(count_a), (13 - (s % 13)) % 13);
      chk($sformatf("down tc k=%0d", k), 32'(tc_a), (k == 5) ? 1 : 0);
    end

    // Corner-case table.
    foreach (vecs[i]) begin
      reset_a = vecs[i].rst; en_a = vecs[i].en; up_a = vecs[i].up;
      load_a = vecs[i].ld; load_val_a = vecs[i].lv;
      cyc();
      $display("vec %0d: count=%0d tick=%0b tc=%0b", i, count_a, tick_a, tc_a);
      chk($sformatf("vec%0d count", i), 32'(count_a), 32'(vecs[i].c));
      chk($sformatf("vec%0d tick", i), 32'(tick_a), 32'(vecs[i].t));
      chk($sformatf("vec%0d tc", i), 32'(tc_a), 32'(vecs[i].tcx));
      chk($sformatf("vec%0d seg", i), 32'(seg_a), seg_of(32'(vecs[i].c)));
    end
    reset_a = 1'b0; en_a = 1'b0; load_a = 1'b0;

    // MODULUS=16, PRESCALE_DIV=1: one step per cycle, and 15 -> 0 raises tc.
    cyc();
    chk("b reset count", 32'(count_b), 0);
    reset_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      $display("b up k=%0d: count=%0d tick=%0b tc=%0b", k, count_b, tick_b, tc_b);
      chk($sformatf("b count k=%0d", k), 32'(count_b), (k - 1) % 16);
      chk($sformatf("b tick k=%0d", k), 32'(tick_b), 1);
      chk($sformatf("b tc k=%0d", k), 32'(tc_b), (k == 17) ? 1 : 0);
    end

    // Loading 15 is legal for MODULUS=16, so it must not saturate.
    load_b = 1'b1; load_val_b = 4'd15;
    cyc();
    $display("b load: count=%0d tick=%0b tc=%0b", count_b, tick_b, tc_b);
    chk("b load count", 32'(count_b), 15);
    chk("b load tick", 32'(tick_b), 0);
    load_b = 1'b0;
    cyc();
    $display("b post-load: count=%0d tick=%0b tc=%0b", count_b, tick_b, tc_b);
    chk("b post-load count", 32'(count_b), 15);
    chk("b post-load tick", 32'(tick_b), 1);
    cyc();
    $display("b wrap: count=%0d tick=%0b tc=%0b", count_b, tick_b, tc_b);
    chk("b wrap count", 32'(count_b), 0);
    chk("b wrap tc", 32'(tc_b), 1);
    chk("b wrap seg", 32'(seg_b), 32'h3F);

    // Direction change takes effect on the very next step: 0 -> 15 with tc.
    up_b = 1'b0;
    cyc();
    $display("b down-wrap: count=%0d tick=%0b tc=%0b", count_b, tick_b, tc_b);
    chk("b down-wrap count", 32'(count_b), 15);
    chk("b down-wrap tc", 32'(tc_b), 1);
    chk("b down-wrap seg", 32'(seg_b), 32'h71);
    cyc();
    $display("b down: count=%0d tick=%0b tc=%0b", count_b, tick_b, tc_b);
    chk("b down count", 32'(count_b), 14);
    chk("b down tc", 32'(tc_b), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
